// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises video, CPU and download accesses onto one SDRAM controller.
// Define ARB_REFRESH_EN to let the arbiter generate periodic refresh strobes itself.
module sdram_arbiter #(
  parameter int AW             = 22,
  parameter int DW             = 8,
  parameter int REFRESH_PERIOD = 276
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vidReq,
  input  logic [AW-1:0] vidA,
  output logic          vidAck,
  output logic [DW-1:0] vidQ,
  input  logic          cpuReq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuA,
  input  logic [DW-1:0] cpuD,
  output logic          cpuAck,
  output logic [DW-1:0] cpuQ,
  input  logic          dlReq,
  input  logic [AW-1:0] dlA,
  input  logic [DW-1:0] dlD,
  output logic          dlAck,
  output logic          memRd,
  output logic          memWr,
  output logic          memRf,
  output logic [AW-1:0] memA,
  output logic [DW-1:0] memD,
  input  logic [DW-1:0] memQ,
  input  logic          memRdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_VID, G_CPU, G_DL, G_RF} grant_t;

  state_t        r_state;
  grant_t        r_grant;
  logic          r_lastDl;
  logic          r_cpuWe;
  logic          r_memRd;
  logic          r_memWr;
  logic          r_memRf;
  logic [AW-1:0] r_memA;
  logic [DW-1:0] r_memD;
  logic          r_vidAck;
  logic          r_cpuAck;
  logic          r_dlAck;
  logic [DW-1:0] r_vidQ;
  logic [DW-1:0] r_cpuQ;
  logic          w_rfPend;

`ifdef ARB_REFRESH_EN
  localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  logic [CW-1:0] r_rfCnt;
  logic          r_rfPend;
  logic          w_rfWrap;
  logic          w_rfDone;

  assign w_rfWrap = (r_rfCnt == CW'(REFRESH_PERIOD - 1));
  assign w_rfDone = (r_state == DONE) && (r_grant == G_RF);

  // A wrap landing on the completing refresh re-arms it; extra wraps never queue up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rfCnt  <= '0;
      r_rfPend <= 1'b0;
    end else begin
      r_rfCnt <= w_rfWrap ? '0 : r_rfCnt + 1'b1;
      if (w_rfWrap)
        r_rfPend <= 1'b1;
      else if (w_rfDone)
        r_rfPend <= 1'b0;
    end
  end

  assign w_rfPend = r_rfPend;
`else
  logic w_unusedPeriod;
  assign w_unusedPeriod = REFRESH_PERIOD[0];
  assign w_rfPend       = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= G_VID;
      r_lastDl <= 1'b1;
      r_cpuWe  <= 1'b0;
      r_memRd  <= 1'b0;
      r_memWr  <= 1'b0;
      r_memRf  <= 1'b0;
      r_memA   <= '0;
      r_memD   <= '0;
      r_vidAck <= 1'b0;
      r_cpuAck <= 1'b0;
      r_dlAck  <= 1'b0;
      r_vidQ   <= '0;
      r_cpuQ   <= '0;
    end else begin
      case (r_state)
        // Strobes are set on the way into ISSUE so they are high for exactly that cycle.
        IDLE: begin
          if (w_rfPend) begin
            r_grant <= G_RF;
            r_memRf <= 1'b1;
            r_state <= ISSUE;
          end else if (vidReq) begin
            r_grant <= G_VID;
            r_memA  <= vidA;
            r_memRd <= 1'b1;
            r_state <= ISSUE;
          end else if (cpuReq && (!dlReq || r_lastDl)) begin
            r_grant  <= G_CPU;
            r_cpuWe  <= cpuWe;
            r_lastDl <= 1'b0;
            r_memA   <= cpuA;
            if (cpuWe)
              r_memD <= cpuD;
            r_memRd  <= !cpuWe;
            r_memWr  <= cpuWe;
            r_state  <= ISSUE;
          end else if (dlReq) begin
            r_grant  <= G_DL;
            r_lastDl <= 1'b1;
            r_memA   <= dlA;
            r_memD   <= dlD;
            r_memWr  <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_memRd <= 1'b0;
          r_memWr <= 1'b0;
          r_memRf <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (memRdy) begin
            case (r_grant)
              G_VID: begin
                r_vidQ   <= memQ;
                r_vidAck <= 1'b1;
              end
              G_CPU: begin
                if (!r_cpuWe)
                  r_cpuQ <= memQ;
                r_cpuAck <= 1'b1;
              end
              G_DL:    r_dlAck <= 1'b1;
              default: ;
            endcase
            r_state <= DONE;
          end
        end
        DONE: begin
          r_vidAck <= 1'b0;
          r_cpuAck <= 1'b0;
          r_dlAck  <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign memRd  = r_memRd;
  assign memWr  = r_memWr;
  assign memRf  = r_memRf;
  assign memA   = r_memA;
  assign memD   = r_memD;
  assign vidAck = r_vidAck;
  assign cpuAck = r_cpuAck;
  assign dlAck  = r_dlAck;
  assign vidQ   = r_vidQ;
  assign cpuQ   = r_cpuQ;

endmodule
